accumulator_8bit: RTL
=====================

ACCUMULATOR_8BIT -- requirements
Module: accumulator_8bit

Interface
REQ-001 Parameters: none; datapath width is fixed at 8 bits.
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  block accepts a command this cycle.
REQ-007 cmd_op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLR.
REQ-008 cmd_data  input  8  operand; ignored for CLR.
REQ-009 res_valid  output  1  acc/zero/ovf hold the result of the last accepted command.
REQ-010 res_ready  input  1  consumer takes the result.
REQ-011 acc  output  8  accumulator value.
REQ-012 zero  output  1  acc == 8'h00.
REQ-013 ovf  output  1  signed two's-complement overflow of the last ADD/SUB.

Function
REQ-014 A command transfer shall occur on a rising edge where cmd_valid && cmd_ready; the block captures cmd_op and cmd_data at that edge.
REQ-015 The FSM shall have exactly three states: IDLE, EXEC and RESP.
REQ-016 IDLE shall drive cmd_ready=1 and go to EXEC on a transfer; otherwise it stays in IDLE.
REQ-017 EXEC shall last exactly one cycle, drive cmd_ready=0, update acc/zero/ovf at its closing edge, and go to RESP.
REQ-018 RESP shall drive res_valid=1 and hold acc/zero/ovf stable until res_ready=1.
REQ-019 In RESP, cmd_ready shall equal res_ready (combinational).
REQ-020 At a RESP edge with res_ready=1 and cmd_valid=1, the result shall retire and the new command shall be accepted in the same cycle, going to EXEC; with res_ready=1 and cmd_valid=0 the next state is IDLE.
REQ-021 Latency: a command accepted at edge N shall have its result visible with res_valid=1 after edge N+1.
REQ-022 Sustained throughput shall be one command per 2 cycles.
REQ-023 LOAD shall set acc=cmd_data and ovf=0.
REQ-024 CLR shall set acc=0 and ovf=0.
REQ-025 ADD shall set acc=(acc+cmd_data) mod 256.
REQ-026 SUB shall set acc=(acc-cmd_data) mod 256; 8'h00-8'h01 gives 8'hFF.
REQ-027 ADD ovf shall be 1 iff both operand signs are equal and the result sign differs from them.
REQ-028 SUB ovf shall be 1 iff the operand signs differ and the result sign differs from acc's old sign.
REQ-029 zero shall be registered with acc and shall equal (acc==0) at all times after reset.
REQ-030 Outputs and state shall not change in IDLE or while RESP stalls.

Reset
REQ-031 When rst_n=0 at a rising edge: state=IDLE, acc=8'h00, zero=1, ovf=0, res_valid=0.
REQ-032 Reset shall take priority over every transfer, including a command in EXEC, which is discarded.
REQ-033 cmd_ready shall be 0 while rst_n=0 and 1 in the first cycle after release.

Structure
REQ-034 A shared package shall hold the cmd_op encodings (OP_LOAD, OP_ADD, OP_SUB, OP_CLR) and the FSM state encoding.
REQ-035 The block shall instantiate exactly one adder_8bit as its arithmetic core: a=operand, b=acc, ctrl=1 for SUB and 0 otherwise.
REQ-036 The block shall contain no other arithmetic operators.

Verification
REQ-037 Reset, then LOAD 8'h05, then ADD 8'h03 -> acc=8'h08, zero=0, ovf=0, with each res_valid one cycle after acceptance.
REQ-038 LOAD 8'h00, SUB 8'h01 -> acc=8'hFF, ovf=0; then ADD 8'h01 -> acc=8'h00, zero=1.
REQ-039 LOAD 8'h7F, ADD 8'h01 -> acc=8'h80, ovf=1; LOAD 8'h80, SUB 8'h01 -> acc=8'h7F, ovf=1.
REQ-040 Hold res_ready=0 for 5 cycles in RESP with cmd_valid=1 -> cmd_ready=0, and acc/zero/ovf stay stable throughout.
REQ-041 Back-to-back: res_ready=1 and cmd_valid=1 held high for ADD 8'h01 x4 from 0 -> one command accepted every 2 cycles, final acc=8'h04.
REQ-042 Assert rst_n=0 during EXEC of ADD 8'h10 with acc=8'h20 -> next cycle acc=8'h00, zero=1, res_valid=0, state IDLE.

Source files
------------

// File: rtl/accumulator_8bit_pkg.sv
// Shared encodings for the 8-bit accumulator: command opcodes, FSM states and
// the captured-command payload.
package accumulator_8bit_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    typedef struct packed {
        op_e               op;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/adder_8bit.sv
// Add/subtract core: sum = b + a (ctrl=0) or b - a (ctrl=1), with signed
// two's-complement overflow.
module adder_8bit
    import accumulator_8bit_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              ctrl,
    output logic [DATA_W-1:0] sum,
    output logic              ovf
);

    logic [DATA_W-1:0] a_eff;

    // Subtraction as b + ~a + 1.
    assign a_eff = a ^ {DATA_W{ctrl}};
    assign sum   = b + a_eff + DATA_W'(ctrl);

    // Overflow when both effective operands share a sign the result does not.
    assign ovf = (a_eff[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != b[DATA_W-1]);

endmodule

// File: rtl/accumulator_8bit.sv
// 8-bit accumulator with a valid/ready command port and a valid/ready result
// port; one command per two cycles when the consumer never stalls.
module accumulator_8bit
    import accumulator_8bit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] acc,
    output logic       zero,
    output logic       ovf
);

    state_e            state;
    state_e            state_next;
    cmd_t              cmd_q;
    logic              transfer_c;
    logic [DATA_W-1:0] sum;
    logic              sum_ovf;
    logic              sub_sel;
    logic [DATA_W-1:0] acc_next;
    logic              ovf_next;

    // State register; res_valid tracks entry into RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
        end else begin
            state     <= state_next;
            res_valid <= (state_next == ST_RESP);
        end
    end

    // Next state and cmd_ready; RESP forwards res_ready so a retiring result
    // can overlap with the next command acceptance.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                cmd_ready = res_ready;
                if (res_ready) begin
                    state_next = cmd_valid ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (!rst_n) begin
            cmd_ready = 1'b0;
        end
    end

    assign transfer_c = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q <= '0;
        end else if (transfer_c) begin
            cmd_q <= '{op: op_e'(cmd_op), data: cmd_data};
        end
    end

    assign sub_sel = (cmd_q.op == OP_SUB);

    adder_8bit u_adder (
        .a    (cmd_q.data),
        .b    (acc),
        .ctrl (sub_sel),
        .sum  (sum),
        .ovf  (sum_ovf)
    );

    // Result select; LOAD and CLR bypass the adder and clear overflow.
    always_comb begin
        acc_next = sum;
        ovf_next = sum_ovf;
        case (cmd_q.op)
            OP_LOAD: begin
                acc_next = cmd_q.data;
                ovf_next = 1'b0;
            end
            OP_CLR: begin
                acc_next = '0;
                ovf_next = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc  <= '0;
            zero <= 1'b1;
            ovf  <= 1'b0;
        end else if (state == ST_EXEC) begin
            acc  <= acc_next;
            zero <= (acc_next == '0);
            ovf  <= ovf_next;
        end
    end

endmodule
